vsdma_wr_ctrl: RTL and testbench
================================

VSDMA_WR_CTRL -- requirements
Module: vsdma_wr_ctrl

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 28, the vsdma address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 256, the beat width.
REQ-003 SHALL have parameter H_BEATS, default 80, the number of beats per video line.
REQ-004 SHALL have parameter V_LINES, default 720, the number of lines per frame.
REQ-005 SHALL have parameter LINE_STRIDE, default 640, the address increment per line (H_BEATS*DATA_WIDTH/32).
REQ-006 SHALL have parameter BASE_ADDR, default 0, the address of frame buffer 0.
REQ-007 SHALL have parameter FRAME_SIZE, default 28'h0080000, the address offset between frame buffers.
REQ-008 SHALL have parameter NUM_FRAMES, default 3, the number of rotating buffers (legal range 1..4).
REQ-009 SHALL have port M_AXI_ACLK, input, 1 bit: the single clock.
REQ-010 SHALL have port M_AXI_ARESETN, input, 1 bit: asynchronous, active-low reset.
REQ-011 SHALL have port vs_frame_start, input, 1 bit: one-cycle pulse marking a new input frame.
REQ-012 SHALL have port fifo_rdata, input, DATA_WIDTH: first-word-fall-through line FIFO data.
REQ-013 SHALL have port fifo_rd_cnt, input, 16 bits: beats currently available in the FIFO.
REQ-014 SHALL have port fifo_rden, output, 1 bit: FIFO pop.
REQ-015 SHALL have port vsdma_waddr, output, ADDR_WIDTH: line start address.
REQ-016 SHALL have port vsdma_wareq, output, 1 bit: line transfer request.
REQ-017 SHALL have port vsdma_wsize, output, 16 bits: beats per request.
REQ-018 SHALL have port vsdma_wbusy, input, 1 bit: downstream transfer in progress.
REQ-019 SHALL have port vsdma_wdata, output, DATA_WIDTH: write data.
REQ-020 SHALL have port vsdma_wvalid, input, 1 bit: beat accepted by downstream.
REQ-021 SHALL have port vsdma_wready, output, 1 bit: data available to downstream.
REQ-022 SHALL have port wr_frame_idx, output, 2 bits: the buffer being written.
REQ-023 SHALL have outputs frame_done (1-cycle pulse) and frame_overrun (sticky), each 1 bit.

Function
REQ-024 SHALL implement FSM states IDLE, WAIT_LINE, REQ, XFER and FRAME_END.
REQ-025 IDLE: on vs_frame_start, SHALL set line_cnt=0 and vsdma_waddr=BASE_ADDR+wr_frame_idx*FRAME_SIZE, then go to WAIT_LINE.
REQ-026 WAIT_LINE: when fifo_rd_cnt>=H_BEATS and vsdma_wbusy==0, SHALL go to REQ.
REQ-027 REQ: SHALL hold vsdma_wareq=1 until vsdma_wbusy==1 is sampled, then deassert vsdma_wareq in the same edge and go to XFER.
REQ-028 vsdma_wsize SHALL be constant H_BEATS.
REQ-029 vsdma_wready SHALL be 1 only in XFER (registered, no combinational input path).
REQ-030 vsdma_wdata SHALL equal fifo_rdata, and fifo_rden SHALL equal vsdma_wvalid, both combinational.
REQ-031 XFER: the beat counter SHALL increment on vsdma_wvalid.
REQ-032 XFER: on the beat with count==H_BEATS-1, the counter SHALL clear, line_cnt SHALL increment and vsdma_waddr SHALL increase by LINE_STRIDE.
REQ-033 XFER: on that final beat, the FSM SHALL go to FRAME_END if line_cnt==V_LINES-1, else to WAIT_LINE.
REQ-034 FRAME_END: frame_done SHALL be 1 for exactly one cycle, and wr_frame_idx SHALL advance modulo NUM_FRAMES (NUM_FRAMES-1 wraps to 0); the FSM then goes to IDLE.
REQ-035 vs_frame_start in any state other than IDLE SHALL be ignored and SHALL set frame_overrun; only reset clears frame_overrun.
REQ-036 Address arithmetic SHALL be ADDR_WIDTH wide, and wrap-around modulo 2^ADDR_WIDTH is permitted.
REQ-037 vsdma_wvalid outside XFER SHALL NOT change any counter.

Reset
REQ-038 While M_AXI_ARESETN==0, asynchronously: state=IDLE, vsdma_wareq=0, vsdma_wready=0, vsdma_waddr=BASE_ADDR, wr_frame_idx=0, line_cnt=0, beat counter=0, frame_done=0, frame_overrun=0.
REQ-039 Reset asserted mid-XFER SHALL abandon the line, and the next frame SHALL restart in buffer 0.

Verification (H_BEATS=4, V_LINES=2, BASE_ADDR=0x100000, FRAME_SIZE=0x40000, LINE_STRIDE=0x20, NUM_FRAMES=3)
REQ-040 Stimulus: frame start, fifo_rd_cnt=8, bench asserts wbusy one cycle after wareq and wvalid each cycle. Required response: requests at 0x100000 then 0x100020, wsize=4, exactly 8 fifo_rden pulses, one frame_done pulse.
REQ-041 Stimulus: three frames. Required response: base addresses 0x100000, 0x140000, 0x180000; a fourth frame returns to 0x100000 with wr_frame_idx=0.
REQ-042 Stimulus: fifo_rd_cnt=3 for 20 cycles, then 4. Required response: no wareq while the count is 3; wareq one cycle after the count reaches 4.
REQ-043 Stimulus: vsdma_wbusy held at 1 in REQ for 10 cycles. Required response: wareq stays 1 until wbusy is sampled, and the FSM does not leave WAIT_LINE while wbusy is high.
REQ-044 Stimulus: vs_frame_start during XFER. Required response: frame_overrun=1, addressing unchanged, frame completes normally.
REQ-045 Stimulus: reset asserted after the 2nd beat of line 0. Required response: all outputs take reset values immediately; the next frame starts at 0x100000.

Source files
------------

// File: rtl/vsdma_wr_ctrl.sv
// Line-oriented write controller: drains a FWFT line FIFO into vsdma write
// requests, one request per video line, rotating across NUM_FRAMES buffers.
module vsdma_wr_ctrl #(
  parameter int unsigned            ADDR_WIDTH  = 28,
  parameter int unsigned            DATA_WIDTH  = 256,
  parameter int unsigned            H_BEATS     = 80,
  parameter int unsigned            V_LINES     = 720,
  parameter int unsigned            LINE_STRIDE = 640,
  parameter logic [ADDR_WIDTH-1:0]  BASE_ADDR   = '0,
  parameter logic [ADDR_WIDTH-1:0]  FRAME_SIZE  = 28'h0080000,
  parameter int unsigned            NUM_FRAMES  = 3
) (
  input  logic                   M_AXI_ACLK,
  input  logic                   M_AXI_ARESETN,
  input  logic                   vs_frame_start,
  input  logic [DATA_WIDTH-1:0]  fifo_rdata,
  input  logic [15:0]            fifo_rd_cnt,
  output logic                   fifo_rden,
  output logic [ADDR_WIDTH-1:0]  vsdma_waddr,
  output logic                   vsdma_wareq,
  output logic [15:0]            vsdma_wsize,
  input  logic                   vsdma_wbusy,
  output logic [DATA_WIDTH-1:0]  vsdma_wdata,
  input  logic                   vsdma_wvalid,
  output logic                   vsdma_wready,
  output logic [1:0]             wr_frame_idx,
  output logic                   frame_done,
  output logic                   frame_overrun
);

  localparam int unsigned BEAT_W = $clog2(H_BEATS + 1);
  localparam int unsigned LINE_W = $clog2(V_LINES + 1);
  localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(H_BEATS - 1);
  localparam logic [LINE_W-1:0] LINE_LAST = LINE_W'(V_LINES - 1);
  localparam logic [1:0]        IDX_LAST  = 2'(NUM_FRAMES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_LINE,
    S_REQ,
    S_XFER,
    S_FRAME_END
  } state_e;

  state_e                  state_q, state_d;
  logic                    wareq_q, wareq_d;
  logic                    wready_q, wready_d;
  logic [ADDR_WIDTH-1:0]   waddr_q, waddr_d;
  logic [1:0]              frame_idx_q, frame_idx_d;
  logic [LINE_W-1:0]       line_cnt_q, line_cnt_d;
  logic [BEAT_W-1:0]       beat_cnt_q, beat_cnt_d;
  logic                    frame_done_q, frame_done_d;
  logic                    overrun_q, overrun_d;
  logic [ADDR_WIDTH-1:0]   frame_base;

  always_comb begin
    frame_base   = BASE_ADDR + ADDR_WIDTH'(frame_idx_q) * FRAME_SIZE;
    state_d      = state_q;
    wareq_d      = wareq_q;
    wready_d     = wready_q;
    waddr_d      = waddr_q;
    frame_idx_d  = frame_idx_q;
    line_cnt_d   = line_cnt_q;
    beat_cnt_d   = beat_cnt_q;
    frame_done_d = 1'b0;
    overrun_d    = overrun_q;

    if (vs_frame_start && (state_q != S_IDLE)) begin
      overrun_d = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (vs_frame_start) begin
          line_cnt_d = '0;
          waddr_d    = frame_base;
          state_d    = S_WAIT_LINE;
        end
      end
      S_WAIT_LINE: begin
        if ((fifo_rd_cnt >= 16'(H_BEATS)) && !vsdma_wbusy) begin
          wareq_d = 1'b1;
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        if (vsdma_wbusy) begin
          wareq_d  = 1'b0;
          wready_d = 1'b1;
          state_d  = S_XFER;
        end
      end
      S_XFER: begin
        if (vsdma_wvalid) begin
          if (beat_cnt_q == BEAT_LAST) begin
            beat_cnt_d = '0;
            line_cnt_d = line_cnt_q + 1'b1;
            waddr_d    = waddr_q + ADDR_WIDTH'(LINE_STRIDE);
            wready_d   = 1'b0;
            if (line_cnt_q == LINE_LAST) begin
              // frame_done is registered on entry so it is high exactly while in FRAME_END
              frame_done_d = 1'b1;
              state_d      = S_FRAME_END;
            end else begin
              state_d = S_WAIT_LINE;
            end
          end else begin
            beat_cnt_d = beat_cnt_q + 1'b1;
          end
        end
      end
      S_FRAME_END: begin
        frame_idx_d = (frame_idx_q == IDX_LAST) ? 2'd0 : frame_idx_q + 2'd1;
        state_d     = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
    if (!M_AXI_ARESETN) begin
      state_q      <= S_IDLE;
      wareq_q      <= 1'b0;
      wready_q     <= 1'b0;
      waddr_q      <= BASE_ADDR;
      frame_idx_q  <= '0;
      line_cnt_q   <= '0;
      beat_cnt_q   <= '0;
      frame_done_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      wareq_q      <= wareq_d;
      wready_q     <= wready_d;
      waddr_q      <= waddr_d;
      frame_idx_q  <= frame_idx_d;
      line_cnt_q   <= line_cnt_d;
      beat_cnt_q   <= beat_cnt_d;
      frame_done_q <= frame_done_d;
      overrun_q    <= overrun_d;
    end
  end

  assign fifo_rden     = vsdma_wvalid;
  assign vsdma_wdata   = fifo_rdata;
  assign vsdma_wsize   = 16'(H_BEATS);
  assign vsdma_waddr   = waddr_q;
  assign vsdma_wareq   = wareq_q;
  assign vsdma_wready  = wready_q;
  assign wr_frame_idx  = frame_idx_q;
  assign frame_done    = frame_done_q;
  assign frame_overrun = overrun_q;

endmodule

// File: tb/tb_vsdma_wr_ctrl.sv
// Directed bench for vsdma_wr_ctrl with a 4-beat, 2-line, 3-buffer geometry.
module tb_vsdma_wr_ctrl;

  logic        clk;
  logic        rst_n;
  logic        vs_frame_start;
  logic [31:0] fifo_rdata;
  logic [15:0] fifo_rd_cnt;
  logic        fifo_rden;
  logic [27:0] waddr;
  logic        wareq;
  logic [15:0] wsize;
  logic        wbusy;
  logic [31:0] wdata;
  logic        wvalid;
  logic        wready;
  logic [1:0]  frame_idx;
  logic        frame_done;
  logic        overrun;

  int checks   = 0;
  int failures = 0;
  int rden_total = 0;
  int done_total = 0;

  vsdma_wr_ctrl #(
    .ADDR_WIDTH  (28),
    .DATA_WIDTH  (32),
    .H_BEATS     (4),
    .V_LINES     (2),
    .LINE_STRIDE (32'h20),
    .BASE_ADDR   (28'h0100000),
    .FRAME_SIZE  (28'h0040000),
    .NUM_FRAMES  (3)
  ) dut (
    .M_AXI_ACLK     (clk),
    .M_AXI_ARESETN  (rst_n),
    .vs_frame_start (vs_frame_start),
    .fifo_rdata     (fifo_rdata),
    .fifo_rd_cnt    (fifo_rd_cnt),
    .fifo_rden      (fifo_rden),
    .vsdma_waddr    (waddr),
    .vsdma_wareq    (wareq),
    .vsdma_wsize    (wsize),
    .vsdma_wbusy    (wbusy),
    .vsdma_wdata    (wdata),
    .vsdma_wvalid   (wvalid),
    .vsdma_wready   (wready),
    .wr_frame_idx   (frame_idx),
    .frame_done     (frame_done),
    .frame_overrun  (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (fifo_rden) rden_total <= rden_total + 1;
    if (frame_done) done_total <= done_total + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One line: wait for the request, answer with wbusy a cycle later, then 4 beats.
  task automatic do_line(input logic [27:0] exp_addr, input bit inject_start);
    int unsigned n;
    n = 0;
    while (!wareq && n < 50) begin
      tick();
      n++;
    end
    chk("wareq_seen", wareq, 1'b1);
    chk("line_addr", waddr, exp_addr);
    chk("wsize", wsize, 16'd4);
    wbusy = 1'b1;
    tick();
    chk("wareq_drop", wareq, 1'b0);
    chk("wready_on", wready, 1'b1);
    for (int b = 0; b < 4; b++) begin
      wvalid         = 1'b1;
      fifo_rdata     = 32'hA500_0000 + 32'(b);
      vs_frame_start = inject_start && (b == 1);
      #1;
      if (b == 2) chk("wdata_path", wdata, 32'hA500_0002);
      tick();
    end
    vs_frame_start = 1'b0;
    wvalid         = 1'b0;
    wbusy          = 1'b0;
    chk("wready_off", wready, 1'b0);
    chk("addr_stride", waddr, exp_addr + 28'h20);
  endtask

  task automatic start_frame(input logic [1:0] exp_idx, input logic [27:0] exp_base);
    chk("frame_idx_pre", frame_idx, exp_idx);
    vs_frame_start = 1'b1;
    tick();
    vs_frame_start = 1'b0;
    chk("frame_base", waddr, exp_base);
  endtask

  task automatic end_frame(input logic [1:0] next_idx);
    chk("frame_done_hi", frame_done, 1'b1);
    tick();
    chk("frame_done_lo", frame_done, 1'b0);
    chk("frame_idx_next", frame_idx, next_idx);
  endtask

  task automatic full_frame(input logic [1:0] idx, input logic [27:0] base, input logic [1:0] next_idx);
    int r0, d0;
    r0 = rden_total;
    d0 = done_total;
    start_frame(idx, base);
    do_line(base, 1'b0);
    do_line(base + 28'h20, 1'b0);
    end_frame(next_idx);
    chk("rden_count", 64'(rden_total - r0), 64'd8);
    chk("done_count", 64'(done_total - d0), 64'd1);
  endtask

  initial begin
    int d0;
    rst_n          = 1'b0;
    vs_frame_start = 1'b0;
    fifo_rdata     = '0;
    fifo_rd_cnt    = 16'd8;
    wbusy          = 1'b0;
    wvalid         = 1'b0;
    #23;
    chk("rst_wareq", wareq, 1'b0);
    chk("rst_wready", wready, 1'b0);
    chk("rst_waddr", waddr, 28'h0100000);
    chk("rst_idx", frame_idx, 2'd0);
    chk("rst_done", frame_done, 1'b0);
    chk("rst_overrun", overrun, 1'b0);
    rst_n = 1'b1;
    tick();

    // wvalid while idle must not disturb the beat counter
    wvalid = 1'b1;
    tick();
    tick();
    wvalid = 1'b0;
    tick();

    full_frame(2'd0, 28'h0100000, 2'd1);
    full_frame(2'd1, 28'h0140000, 2'd2);
    full_frame(2'd2, 28'h0180000, 2'd0);
    full_frame(2'd0, 28'h0100000, 2'd1);
    chk("no_overrun", overrun, 1'b0);

    // Insufficient FIFO level holds off the request
    fifo_rd_cnt = 16'd3;
    start_frame(2'd1, 28'h0140000);
    for (int i = 0; i < 20; i++) begin
      chk("starved_wareq", wareq, 1'b0);
      tick();
    end
    fifo_rd_cnt = 16'd4;
    tick();
    chk("fed_wareq", wareq, 1'b1);
    do_line(28'h0140000, 1'b0);
    do_line(28'h0140020, 1'b0);
    end_frame(2'd2);
    fifo_rd_cnt = 16'd8;

    // Busy downstream blocks WAIT_LINE; request then held until wbusy seen
    wbusy = 1'b1;
    start_frame(2'd2, 28'h0180000);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("busy_no_req", wareq, 1'b0);
    end
    wbusy = 1'b0;
    tick();
    chk("req_after_busy", wareq, 1'b1);
    wvalid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("req_held", wareq, 1'b1);
      chk("req_no_wready", wready, 1'b0);
    end
    wvalid = 1'b0;
    do_line(28'h0180000, 1'b0);
    do_line(28'h0180020, 1'b0);
    end_frame(2'd0);

    // Frame start during XFER sets overrun and is otherwise ignored
    d0 = done_total;
    start_frame(2'd0, 28'h0100000);
    do_line(28'h0100000, 1'b1);
    chk("overrun_set", overrun, 1'b1);
    do_line(28'h0100020, 1'b0);
    end_frame(2'd1);
    chk("overrun_sticky", overrun, 1'b1);
    chk("overrun_done_count", 64'(done_total - d0), 64'd1);

    // Reset after the 2nd beat of line 0
    start_frame(2'd1, 28'h0140000);
    tick();
    chk("mid_wareq", wareq, 1'b1);
    wbusy = 1'b1;
    tick();
    wvalid = 1'b1;
    tick();
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_wready", wready, 1'b0);
    chk("arst_wareq", wareq, 1'b0);
    chk("arst_waddr", waddr, 28'h0100000);
    chk("arst_idx", frame_idx, 2'd0);
    chk("arst_overrun", overrun, 1'b0);
    chk("arst_done", frame_done, 1'b0);
    wvalid = 1'b0;
    wbusy  = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    full_frame(2'd0, 28'h0100000, 2'd1);
    chk("post_rst_overrun", overrun, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
